// File: rtl/cfu_bus_buffer.sv
// Registered buffer between the CPU CFU port and the Cfu block:
// FWFT command FIFO downstream, 2-entry skid buffer on the response return.
module cfu_bus_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_cmd_valid,
   output logic             s_cmd_ready,
   input  logic [2:0]       s_cmd_function_id,
   input  logic [31:0]      s_cmd_inputs_0,
   input  logic [31:0]      s_cmd_inputs_1,
   output logic             m_cmd_valid,
   input  logic             m_cmd_ready,
   output logic [2:0]       m_cmd_function_id,
   output logic [31:0]      m_cmd_inputs_0,
   output logic [31:0]      m_cmd_inputs_1,
   input  logic             m_rsp_valid,
   output logic             m_rsp_ready,
   input  logic             m_rsp_response_ok,
   input  logic [31:0]      m_rsp_outputs_0,
   output logic             s_rsp_valid,
   input  logic             s_rsp_ready,
   output logic             s_rsp_response_ok,
   output logic [31:0]      s_rsp_outputs_0,
   output logic [LVL_W-1:0] cmd_level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CMD_W = 67;
   localparam int unsigned RSP_W = 33;

   typedef enum logic [1:0] {
      RSP_EMPTY,
      RSP_ONE,
      RSP_TWO
   } rsp_state_t;

   // ---------------- command FIFO ----------------
   logic [CMD_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level_nx;
   logic             push;
   logic             pop;

   assign push = s_cmd_valid && s_cmd_ready;
   assign pop  = m_cmd_valid && m_cmd_ready;

   always_comb begin
      level_nx = cmd_level;
      if (push && !pop) begin
         level_nx = cmd_level + LVL_W'(1);
      end else if (pop && !push) begin
         level_nx = cmd_level - LVL_W'(1);
      end
   end

   // Ready/valid are flopped from the next level so neither depends on the far side combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cmd_level   <= '0;
         s_cmd_ready <= 1'b1;
         m_cmd_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         cmd_level   <= level_nx;
         s_cmd_ready <= (level_nx != LVL_W'(DEPTH));
         m_cmd_valid <= (level_nx != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s_cmd_function_id, s_cmd_inputs_1, s_cmd_inputs_0};
   end

   assign {m_cmd_function_id, m_cmd_inputs_1, m_cmd_inputs_0} = mem[rd_ptr];

   // ---------------- response skid buffer ----------------
   rsp_state_t       state_q;
   rsp_state_t       state_d;
   logic [RSP_W-1:0] head_q;
   logic [RSP_W-1:0] tail_q;
   logic             accept;
   logic             drain;
   logic             head_load_in;
   logic             head_load_tail;
   logic             tail_load_in;

   assign accept = m_rsp_valid && m_rsp_ready;
   assign drain  = s_rsp_valid && s_rsp_ready;

   always_comb begin
      state_d        = state_q;
      head_load_in   = 1'b0;
      head_load_tail = 1'b0;
      tail_load_in   = 1'b0;
      unique case (state_q)
         RSP_EMPTY: begin
            if (accept) begin
               state_d      = RSP_ONE;
               head_load_in = 1'b1;
            end
         end
         RSP_ONE: begin
            if (accept && drain) begin
               head_load_in = 1'b1;
            end else if (accept) begin
               state_d      = RSP_TWO;
               tail_load_in = 1'b1;
            end else if (drain) begin
               state_d = RSP_EMPTY;
            end
         end
         RSP_TWO: begin
            if (drain) begin
               state_d        = RSP_ONE;
               head_load_tail = 1'b1;
            end
         end
         default: state_d = RSP_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RSP_EMPTY;
         m_rsp_ready <= 1'b1;
         s_rsp_valid <= 1'b0;
      end else begin
         state_q     <= state_d;
         m_rsp_ready <= (state_d != RSP_TWO);
         s_rsp_valid <= (state_d != RSP_EMPTY);
      end
   end

   always_ff @(posedge clk) begin
      if (head_load_in)        head_q <= {m_rsp_response_ok, m_rsp_outputs_0};
      else if (head_load_tail) head_q <= tail_q;
      if (tail_load_in)        tail_q <= {m_rsp_response_ok, m_rsp_outputs_0};
   end

   assign {s_rsp_response_ok, s_rsp_outputs_0} = head_q;

endmodule

// File: tb/tb_cfu_bus_buffer.sv
// Scoreboard bench for cfu_bus_buffer: directed stimulus, negedge monitor
// compares every delivered command/response against the queued expectation.
module tb_cfu_bus_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LVL_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             s_cmd_valid;
   logic             s_cmd_ready;
   logic [2:0]       s_cmd_function_id;
   logic [31:0]      s_cmd_inputs_0;
   logic [31:0]      s_cmd_inputs_1;
   logic             m_cmd_valid;
   logic             m_cmd_ready;
   logic [2:0]       m_cmd_function_id;
   logic [31:0]      m_cmd_inputs_0;
   logic [31:0]      m_cmd_inputs_1;
   logic             m_rsp_valid;
   logic             m_rsp_ready;
   logic             m_rsp_response_ok;
   logic [31:0]      m_rsp_outputs_0;
   logic             s_rsp_valid;
   logic             s_rsp_ready;
   logic             s_rsp_response_ok;
   logic [31:0]      s_rsp_outputs_0;
   logic [LVL_W-1:0] cmd_level;

   cfu_bus_buffer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk(clk), .rst(rst),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
      .s_cmd_function_id(s_cmd_function_id),
      .s_cmd_inputs_0(s_cmd_inputs_0), .s_cmd_inputs_1(s_cmd_inputs_1),
      .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
      .m_cmd_function_id(m_cmd_function_id),
      .m_cmd_inputs_0(m_cmd_inputs_0), .m_cmd_inputs_1(m_cmd_inputs_1),
      .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
      .m_rsp_response_ok(m_rsp_response_ok), .m_rsp_outputs_0(m_rsp_outputs_0),
      .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready),
      .s_rsp_response_ok(s_rsp_response_ok), .s_rsp_outputs_0(s_rsp_outputs_0),
      .cmd_level(cmd_level)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          passed = 0;
   logic [66:0] cmd_q[$];
   logic [32:0] rsp_q[$];
   logic [31:0] got_in0[$];
   logic [31:0] got_rsp[$];

   task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic timeout(input string name);
      total++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic wait_cmd_empty();
      for (int i = 0; i < 50 && cmd_level != 0; i++) tick();
      if (cmd_level != 0) timeout("cmd_drain");
   endtask

   // Scoreboard: expectations enqueue on each accepted input, pop on each delivered output.
   always @(negedge clk) begin
      if (!rst) begin
         if (s_cmd_valid && s_cmd_ready)
            cmd_q.push_back({s_cmd_function_id, s_cmd_inputs_1, s_cmd_inputs_0});
         if (m_cmd_valid && m_cmd_ready) begin
            got_in0.push_back(m_cmd_inputs_0);
            if (cmd_q.size() == 0) timeout("cmd_unexpected");
            else chk("cmd_order", {m_cmd_function_id, m_cmd_inputs_1, m_cmd_inputs_0},
                     cmd_q.pop_front());
         end
         if (m_rsp_valid && m_rsp_ready)
            rsp_q.push_back({m_rsp_response_ok, m_rsp_outputs_0});
         if (s_rsp_valid && s_rsp_ready) begin
            got_rsp.push_back(s_rsp_outputs_0);
            if (rsp_q.size() == 0) timeout("rsp_unexpected");
            else chk("rsp_order", 67'({s_rsp_response_ok, s_rsp_outputs_0}),
                     67'(rsp_q.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1;
      s_cmd_valid = 1'b0; s_cmd_function_id = '0; s_cmd_inputs_0 = '0; s_cmd_inputs_1 = '0;
      m_cmd_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_response_ok = 1'b0; m_rsp_outputs_0 = '0;
      s_rsp_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset / idle
      chk("rst_level", 67'(cmd_level), 67'(0));
      chk("rst_m_cmd_valid", 67'(m_cmd_valid), 67'(0));
      chk("rst_s_rsp_valid", 67'(s_rsp_valid), 67'(0));
      chk("rst_s_cmd_ready", 67'(s_cmd_ready), 67'(1));
      chk("rst_m_rsp_ready", 67'(m_rsp_ready), 67'(1));

      // single push, 1-cycle latency, payload held stable
      s_cmd_valid = 1'b1; s_cmd_function_id = 3'd1;
      s_cmd_inputs_0 = 32'h11; s_cmd_inputs_1 = 32'h22;
      chk("lat_not_same_cycle", 67'(m_cmd_valid), 67'(0));
      tick();
      s_cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 67'(m_cmd_valid), 67'(1));
         chk("hold_payload", {m_cmd_function_id, m_cmd_inputs_1, m_cmd_inputs_0},
             {3'd1, 32'h22, 32'h11});
         chk("hold_level", 67'(cmd_level), 67'(1));
         tick();
      end
      m_cmd_ready = 1'b1;
      tick();
      m_cmd_ready = 1'b0;
      chk("single_drained", 67'(cmd_level), 67'(0));

      // overfill: 4 accepted, 5th waits for ready to rise
      got_in0.delete();
      for (int i = 1; i <= 4; i++) begin
         s_cmd_valid = 1'b1; s_cmd_function_id = 3'(i); s_cmd_inputs_0 = 32'(i);
         s_cmd_inputs_1 = 32'(i * 16);
         tick();
      end
      s_cmd_function_id = 3'd5; s_cmd_inputs_0 = 32'd5; s_cmd_inputs_1 = 32'd80;
      chk("full_ready", 67'(s_cmd_ready), 67'(0));
      chk("full_level", 67'(cmd_level), 67'(4));
      repeat (2) tick();
      chk("full_hold_level", 67'(cmd_level), 67'(4));
      m_cmd_ready = 1'b1;
      chk("full_ready_no_passthru", 67'(s_cmd_ready), 67'(0));
      tick();
      chk("ready_rise_after_pop", 67'(s_cmd_ready), 67'(1));
      chk("level_after_pop", 67'(cmd_level), 67'(3));
      tick();
      s_cmd_valid = 1'b0;
      wait_cmd_empty();
      m_cmd_ready = 1'b0;
      chk("fill_count", 67'(got_in0.size()), 67'(5));
      for (int i = 0; i < 5 && i < got_in0.size(); i++)
         chk("fill_order", 67'(got_in0[i]), 67'(i + 1));

      // steady push+pop at level 2, pointers wrap
      got_in0.delete();
      for (int i = 0; i < 2; i++) begin
         s_cmd_valid = 1'b1; s_cmd_function_id = 3'd2;
         s_cmd_inputs_0 = 32'h100 + 32'(i); s_cmd_inputs_1 = 32'hBEEF;
         tick();
      end
      chk("steady_start_level", 67'(cmd_level), 67'(2));
      m_cmd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_cmd_inputs_0 = 32'h102 + 32'(i);
         tick();
         chk("steady_level", 67'(cmd_level), 67'(2));
      end
      s_cmd_valid = 1'b0;
      wait_cmd_empty();
      m_cmd_ready = 1'b0;
      chk("steady_count", 67'(got_in0.size()), 67'(10));
      for (int i = 0; i < 10 && i < got_in0.size(); i++)
         chk("steady_order", 67'(got_in0[i]), 67'(32'h100 + 32'(i)));

      // response skid: fill to two, third held by Cfu, then release
      got_rsp.delete();
      s_rsp_ready = 1'b0;
      m_rsp_valid = 1'b1; m_rsp_response_ok = 1'b1; m_rsp_outputs_0 = 32'hA;
      chk("rsp_ready_empty", 67'(m_rsp_ready), 67'(1));
      tick();
      m_rsp_response_ok = 1'b0; m_rsp_outputs_0 = 32'hB;
      chk("rsp_latency", 67'(s_rsp_valid), 67'(1));
      chk("rsp_head_a", 67'(s_rsp_outputs_0), 67'(32'hA));
      tick();
      m_rsp_response_ok = 1'b1; m_rsp_outputs_0 = 32'hC;
      chk("rsp_two_not_ready", 67'(m_rsp_ready), 67'(0));
      repeat (2) tick();
      chk("rsp_two_still_a", 67'(s_rsp_outputs_0), 67'(32'hA));
      chk("rsp_two_hold", 67'(m_rsp_ready), 67'(0));
      s_rsp_ready = 1'b1;
      tick();
      chk("rsp_head_b", 67'(s_rsp_outputs_0), 67'(32'hB));
      chk("rsp_ready_back", 67'(m_rsp_ready), 67'(1));
      tick();
      m_rsp_valid = 1'b0;
      chk("rsp_head_c", 67'(s_rsp_outputs_0), 67'(32'hC));
      tick();
      chk("rsp_empty", 67'(s_rsp_valid), 67'(0));
      chk("rsp_count", 67'(got_rsp.size()), 67'(3));
      if (got_rsp.size() == 3) begin
         chk("rsp_seq0", 67'(got_rsp[0]), 67'(32'hA));
         chk("rsp_seq1", 67'(got_rsp[1]), 67'(32'hB));
         chk("rsp_seq2", 67'(got_rsp[2]), 67'(32'hC));
      end

      // asynchronous reset with FIFO at 3 and skid full
      s_rsp_ready = 1'b0; m_cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_cmd_valid = 1'b1; s_cmd_function_id = 3'd3; s_cmd_inputs_0 = 32'h31 + 32'(i);
         m_rsp_valid = (i < 2); m_rsp_outputs_0 = 32'hD0 + 32'(i);
         tick();
      end
      s_cmd_valid = 1'b0; m_rsp_valid = 1'b0;
      chk("pre_rst_level", 67'(cmd_level), 67'(3));
      chk("pre_rst_skid_full", 67'(m_rsp_ready), 67'(0));
      #3;
      rst = 1'b1;
      cmd_q.delete(); rsp_q.delete();
      #1;
      chk("arst_m_cmd_valid", 67'(m_cmd_valid), 67'(0));
      chk("arst_s_rsp_valid", 67'(s_rsp_valid), 67'(0));
      chk("arst_level", 67'(cmd_level), 67'(0));
      chk("arst_s_cmd_ready", 67'(s_cmd_ready), 67'(1));
      chk("arst_m_rsp_ready", 67'(m_rsp_ready), 67'(1));
      @(negedge clk);
      #2;
      rst = 1'b0;
      tick();
      got_in0.delete();
      s_cmd_valid = 1'b1; s_cmd_function_id = 3'd5;
      s_cmd_inputs_0 = 32'h77; s_cmd_inputs_1 = 32'h0;
      tick();
      s_cmd_valid = 1'b0;
      chk("post_rst_level", 67'(cmd_level), 67'(1));
      chk("post_rst_head", 67'(m_cmd_inputs_0), 67'(32'h77));
      m_cmd_ready = 1'b1;
      tick();
      m_cmd_ready = 1'b0;
      chk("post_rst_count", 67'(got_in0.size()), 67'(1));
      if (got_in0.size() == 1) chk("post_rst_first", 67'(got_in0[0]), 67'(32'h77));
      chk("post_rst_no_replay", 67'(s_rsp_valid), 67'(0));

      chk("cmd_sb_empty", 67'(cmd_q.size()), 67'(0));
      chk("rsp_sb_empty", 67'(rsp_q.size()), 67'(0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/cfu_bus_buffer.md
Name: cfu_bus_buffer

Overview:
- Registered buffering stage between the CPU's CFU port and the Cfu block.
- Upstream (s_*) faces the CPU; downstream (m_*) drives the Cfu cmd bus and accepts its rsp bus.
- Command path: first-word-fall-through FIFO, DEPTH deep. Response path: 2-entry skid buffer.
- Breaks the combinational ready/valid loop of a combinational Cfu. Preserves command order and response order.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- LVL_W, $clog2(DEPTH)+1, width of cmd_level.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_cmd_valid  in  1  CPU command valid.
- s_cmd_ready  out  1  FIFO can accept.
- s_cmd_function_id  in  3  function id.
- s_cmd_inputs_0  in  32  operand 0.
- s_cmd_inputs_1  in  32  operand 1.
- m_cmd_valid  out  1  to Cfu io_bus_cmd_valid.
- m_cmd_ready  in  1  from Cfu io_bus_cmd_ready.
- m_cmd_function_id  out  3  to Cfu.
- m_cmd_inputs_0  out  32  to Cfu.
- m_cmd_inputs_1  out  32  to Cfu.
- m_rsp_valid  in  1  from Cfu io_bus_rsp_valid.
- m_rsp_ready  out  1  to Cfu io_bus_rsp_ready.
- m_rsp_response_ok  in  1  from Cfu.
- m_rsp_outputs_0  in  32  from Cfu.
- s_rsp_valid  out  1  response to CPU.
- s_rsp_ready  in  1  CPU accepts response.
- s_rsp_response_ok  out  1  to CPU.
- s_rsp_outputs_0  out  32  to CPU.
- cmd_level  out  LVL_W  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, applies immediately):
  - FIFO pointers and cmd_level go to 0.
  - Skid entries are invalidated: m_cmd_valid=0, s_rsp_valid=0, s_cmd_ready=1, m_rsp_ready=1.
  - Data outputs are don't-care while their valid is low.
  - Asserting reset mid-transfer discards all queued commands and responses; nothing is replayed after release.
- Command FIFO:
  - 67-bit entry = {function_id, inputs_1, inputs_0}.
  - Push when s_cmd_valid && s_cmd_ready.
  - Pop when m_cmd_valid && m_cmd_ready.
  - s_cmd_ready = (cmd_level != DEPTH). Registered-state decode only; it does not depend on m_cmd_ready, so there is no combinational pass-through.
  - m_cmd_valid = (cmd_level != 0). The m_cmd_* payload is the head entry, stable while valid and not popped.
  - Latency: a command pushed in cycle N is first visible on m_cmd in cycle N+1. It is never visible in cycle N, even when the FIFO is empty.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
  - Full: s_cmd_ready=0. A pop in that cycle frees a slot, but ready rises only in the next cycle.
  - Empty: m_cmd_valid=0. m_cmd_ready is ignored.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. cmd_level is tracked explicitly.
  - cmd_level is +1 on push-only, -1 on pop-only, unchanged otherwise.
- Response skid buffer (states EMPTY, ONE, TWO):
  - m_rsp_ready = (state != TWO), registered.
  - s_rsp_valid = (state != EMPTY). s_rsp_* always presents the oldest entry.
  - EMPTY: m_rsp accepted -> ONE.
  - ONE:
    - accept without drain -> TWO.
    - drain without accept -> EMPTY.
    - accept and drain -> stays ONE; the new entry becomes head.
  - TWO:
    - drain -> ONE; the second entry moves to head.
    - m_rsp_ready=0, so no accept occurs.
  - Response latency is 1 cycle: a response accepted in cycle N is on s_rsp in N+1.
  - response_ok and outputs_0 are carried unmodified.
- Ordering: strict FIFO on both paths. No reordering and no dropping except by reset.
- Full throughput: with a combinational Cfu and the CPU always ready, one command per cycle is sustained in steady state.

Test Plan:
- Reset then idle -> cmd_level=0, m_cmd_valid=0, s_rsp_valid=0, s_cmd_ready=1, m_rsp_ready=1.
- Push fid=1, in0=0x11, in1=0x22 in cycle 0 with m_cmd_ready=0 -> m_cmd_valid=1 from cycle 1 with the same payload; held stable for 5 cycles; cmd_level=1.
- Push 5 commands (in0=1..5), DEPTH=4, m_cmd_ready=0 -> first 4 accepted, s_cmd_ready=0 from cycle 4, cmd_level=4. Then assert m_cmd_ready=1 -> Cfu receives in0=1,2,3,4,5 in order, and the 5th is accepted only after the ready rise.
- Back-to-back push and pop at level 2 for 8 cycles -> cmd_level stays 2; pointers wrap past DEPTH; data order intact.
- Cfu returns outputs_0=0xA, 0xB, 0xC on consecutive cycles with s_rsp_ready=0 -> 0xA and 0xB stored, m_rsp_ready=0 after the second; 0xC is held by the Cfu. Release s_rsp_ready -> CPU sees 0xA, 0xB, 0xC in order.
- Fill FIFO to 3 and skid to TWO, then assert rst asynchronously mid-cycle -> all valids drop at once, cmd_level=0. After release, a new command 0x77 is the first on m_cmd.
